// File: rtl/dram_bank_arbiter.sv
// Two-requester read scheduler in front of one dram_bank. Row hits are favoured,
// otherwise requesters alternate; one read is outstanding at a time.
module dram_bank_arbiter #(
    parameter int ROW_W    = 4,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 15,
    parameter int MAX_HITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ROW_W-1:0]  req0_row,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    input  logic              req1_valid,
    input  logic [ROW_W-1:0]  req1_row,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic [ROW_W-1:0]  bank_row_num,
    output logic              bank_input_valid,
    input  logic [DATA_W-1:0] bank_output_data,
    input  logic              bank_output_valid,
    output logic [ROW_W-1:0]  open_row,
    output logic              open_row_valid,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int HS_W  = $clog2(MAX_HITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_rr_ptr;
    logic [HS_W-1:0]     r_hit_streak;
    logic [ROW_W-1:0]    r_open_row;
    logic                r_open_row_valid;
    logic                r_timeout_err;
    logic [ROW_W-1:0]    r_row;
    logic                r_id;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_resp0_valid;
    logic                r_resp1_valid;
    logic [DATA_W-1:0]   r_resp_data;

    logic w_idle;
    logic w_both;
    logic w_hit0;
    logic w_hit1;
    logic w_use_hit;
    logic w_winner;
    logic w_accept;
    logic w_complete;
    logic w_timeout;

    // A hit override applies only when exactly one of two contenders hits.
    assign w_idle     = (r_state == S_IDLE);
    assign w_both     = req0_valid & req1_valid;
    assign w_hit0     = r_open_row_valid & (req0_row == r_open_row);
    assign w_hit1     = r_open_row_valid & (req1_row == r_open_row);
    assign w_use_hit  = w_both & (w_hit0 ^ w_hit1) & (r_hit_streak < HS_W'(MAX_HITS));
    assign w_winner   = !w_both ? req1_valid : (w_use_hit ? w_hit1 : r_rr_ptr);
    assign w_accept   = w_idle & (req0_valid | req1_valid);
    assign w_complete = ((r_state == S_ISSUE) | (r_state == S_WAIT)) & bank_output_valid;
    assign w_timeout  = (r_state == S_WAIT) & !bank_output_valid &
                        (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = bank_output_valid ? S_IDLE : S_WAIT;
            S_WAIT:  if (bank_output_valid || w_timeout) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready       = !rst & w_idle & req0_valid & !w_winner;
        req1_ready       = !rst & w_idle & req1_valid & w_winner;
        bank_input_valid = (r_state == S_ISSUE);
        bank_row_num     = r_row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr         <= 1'b0;
            r_hit_streak     <= '0;
            r_open_row       <= '0;
            r_open_row_valid <= 1'b0;
            r_timeout_err    <= 1'b0;
            r_row            <= '0;
            r_id             <= 1'b0;
            r_wait_cnt       <= '0;
            r_resp0_valid    <= 1'b0;
            r_resp1_valid    <= 1'b0;
            r_resp_data      <= '0;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            if (w_accept) begin
                r_row        <= w_winner ? req1_row : req0_row;
                r_id         <= w_winner;
                r_hit_streak <= w_use_hit ? r_hit_streak + HS_W'(1) : '0;
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_complete) begin
                r_resp0_valid    <= !r_id;
                r_resp1_valid    <= r_id;
                r_resp_data      <= bank_output_data;
                r_open_row       <= r_row;
                r_open_row_valid <= 1'b1;
                r_rr_ptr         <= !r_id;
            end else if (w_timeout) begin
                // Answer with zero data so the requester is never left hanging.
                r_resp0_valid    <= !r_id;
                r_resp1_valid    <= r_id;
                r_resp_data      <= '0;
                r_open_row_valid <= 1'b0;
                r_timeout_err    <= 1'b1;
            end
        end
    end

    assign resp0_valid    = r_resp0_valid;
    assign resp1_valid    = r_resp1_valid;
    assign resp0_data     = r_resp0_valid ? r_resp_data : '0;
    assign resp1_data     = r_resp1_valid ? r_resp_data : '0;
    assign open_row       = r_open_row;
    assign open_row_valid = r_open_row_valid;
    assign timeout_err    = r_timeout_err;
endmodule

// File: tb/tb_dram_bank_arbiter.sv
// Bench for dram_bank_arbiter: behavioural bank, directed vector table,
// hand sequences for timeout and reset, and a randomized transaction-level model.
module tb_dram_bank_arbiter;
    localparam int ROW_W    = 4;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 15;
    localparam int MAX_HITS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ROW_W-1:0]  req0_row, req1_row;
    logic              req0_ready, req1_ready;
    logic              resp0_valid, resp1_valid;
    logic [DATA_W-1:0] resp0_data, resp1_data;
    logic [ROW_W-1:0]  bank_row_num;
    logic              bank_input_valid;
    logic [DATA_W-1:0] bank_output_data;
    logic              bank_output_valid;
    logic [ROW_W-1:0]  open_row;
    logic              open_row_valid;
    logic              timeout_err;

    dram_bank_arbiter #(.ROW_W(ROW_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_HITS(MAX_HITS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_row(req0_row), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_row(req1_row), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .bank_row_num(bank_row_num), .bank_input_valid(bank_input_valid),
        .bank_output_data(bank_output_data), .bank_output_valid(bank_output_valid),
        .open_row(open_row), .open_row_valid(open_row_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural bank: same-cycle data on an open-row hit, miss_lat cycles otherwise.
    int          miss_lat;
    logic        bank_never;
    logic [31:0] salt;
    logic        bank_open_valid;
    logic [3:0]  bank_open, bank_prow;
    int          bank_cnt;
    logic        bov_model, bov_inject;
    logic [31:0] bdata_model;

    assign bank_output_valid = bov_model | bov_inject;
    assign bank_output_data  = bdata_model;

    function automatic logic [31:0] bank_data(input logic [3:0] r);
        return salt ^ ({28'd0, r} * 32'h0101_0101) ^ 32'h00A5_0000;
    endfunction

    always @(negedge clk) begin
        bov_model   = 1'b0;
        bdata_model = $urandom;
        if (rst) begin
            bank_cnt        = 0;
            bank_open_valid = 1'b0;
        end else if (bank_input_valid) begin
            bank_prow = bank_row_num;
            if (bank_never) begin
                bank_cnt = 0;
            end else if (bank_open_valid && bank_row_num == bank_open) begin
                bov_model   = 1'b1;
                bdata_model = bank_data(bank_row_num);
            end else begin
                bank_cnt = miss_lat;
            end
        end else if (bank_cnt > 0) begin
            bank_cnt--;
            if (bank_cnt == 0) begin
                bov_model       = 1'b1;
                bdata_model     = bank_data(bank_prow);
                bank_open       = bank_prow;
                bank_open_valid = 1'b1;
            end
        end
    end

    task automatic do_txn(input logic v0, input logic [3:0] r0, input logic v1, input logic [3:0] r1,
                          output int gid, output int rid, output int lat, output logic [31:0] rdata);
        gid = -1; rid = -1; lat = -1; rdata = '0;
        @(negedge clk);
        req0_valid = v0; req0_row = r0; req1_valid = v1; req1_row = r1;
        for (int t = 0; t < 20 && gid < 0; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (req0_ready && req1_ready) gid = 2;
            else if (req0_ready) gid = 0;
            else if (req1_ready) gid = 1;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (gid < 0) begin
            checks++; errors++;
            $display("FAIL grant_wait actual=none required=grant");
            return;
        end
        for (int n = 1; n < 40 && rid < 0; n++) begin
            if (n > 1) @(negedge clk);
            #1;
            if (resp0_valid && resp1_valid) rid = 2;
            else if (resp0_valid) begin rid = 0; rdata = resp0_data; end
            else if (resp1_valid) begin rid = 1; rdata = resp1_data; end
            if (rid >= 0) lat = n - 2;
        end
        if (rid < 0) begin
            checks++; errors++;
            $display("FAIL resp_wait actual=none required=response");
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_resp0"}, resp0_valid, 0);
        chk({tag, "_resp1"}, resp1_valid, 0);
        chk({tag, "_bank_iv"}, bank_input_valid, 0);
        chk({tag, "_bank_row"}, bank_row_num, 0);
        chk({tag, "_open_row"}, open_row, 0);
        chk({tag, "_orv"}, open_row_valid, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    typedef struct {
        logic       v0;
        logic [3:0] r0;
        logic       v1;
        logic [3:0] r1;
        int         eid;
        logic [3:0] erow;
        logic       ehit;
    } vec_t;

    vec_t vt[16];

    // Transaction-level reference state for the random phase
    logic [3:0]  m_open;
    logic        m_orv;
    int          m_streak, m_rr, m_free, m_rcyc, m_rid, ew;
    logic        m_pend, h0, h1, mhit, acc0, acc1;
    logic [3:0]  mrow;
    logic [31:0] m_rdata;
    int          gid, rid, lat;
    logic [31:0] rdata;

    function automatic logic [3:0] pick_row();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 2));
    endfunction

    initial begin
        // row 8 is the hit row in the starvation-cap run (entries 6..10)
        vt[0]  = '{1'b1, 4'd0,  1'b0, 4'd0,  0, 4'd0,  1'b0};
        vt[1]  = '{1'b1, 4'd1,  1'b1, 4'd2,  1, 4'd2,  1'b0};
        vt[2]  = '{1'b1, 4'd1,  1'b1, 4'd2,  1, 4'd2,  1'b1};
        vt[3]  = '{1'b1, 4'd5,  1'b1, 4'd5,  0, 4'd5,  1'b0};
        vt[4]  = '{1'b1, 4'd5,  1'b1, 4'd5,  1, 4'd5,  1'b1};
        vt[5]  = '{1'b0, 4'd0,  1'b1, 4'd8,  1, 4'd8,  1'b0};
        vt[6]  = '{1'b1, 4'd15, 1'b1, 4'd8,  1, 4'd8,  1'b1};
        vt[7]  = '{1'b1, 4'd15, 1'b1, 4'd8,  1, 4'd8,  1'b1};
        vt[8]  = '{1'b1, 4'd15, 1'b1, 4'd8,  1, 4'd8,  1'b1};
        vt[9]  = '{1'b1, 4'd15, 1'b1, 4'd8,  1, 4'd8,  1'b1};
        vt[10] = '{1'b1, 4'd15, 1'b1, 4'd8,  0, 4'd15, 1'b0};
        vt[11] = '{1'b1, 4'd3,  1'b1, 4'd15, 1, 4'd15, 1'b1};
        vt[12] = '{1'b1, 4'd1,  1'b1, 4'd2,  0, 4'd1,  1'b0};
        vt[13] = '{1'b1, 4'd3,  1'b1, 4'd4,  1, 4'd4,  1'b0};
        vt[14] = '{1'b1, 4'd5,  1'b1, 4'd6,  0, 4'd5,  1'b0};
        vt[15] = '{1'b1, 4'd7,  1'b1, 4'd9,  1, 4'd9,  1'b0};

        miss_lat = 2; bank_never = 1'b0; salt = 32'hC0DE_0000;
        bov_inject = 1'b0; bank_open = 4'd0; bank_prow = 4'd0;
        rst = 1'b1;
        req0_valid = 1'b1; req0_row = 4'd3; req1_valid = 1'b1; req1_row = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_txn(vt[i].v0, vt[i].r0, vt[i].v1, vt[i].r1, gid, rid, lat, rdata);
            chk($sformatf("vec%0d_grant", i), gid, vt[i].eid);
            chk($sformatf("vec%0d_resp_id", i), rid, vt[i].eid);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].ehit ? 0 : miss_lat);
            chk($sformatf("vec%0d_data", i), rdata, bank_data(vt[i].erow));
            chk($sformatf("vec%0d_open_row", i), open_row, vt[i].erow);
            chk($sformatf("vec%0d_orv", i), open_row_valid, 1);
            $display("vec %0d grant=%0d resp=%0d lat=%0d data=%08h", i, gid, rid, lat, rdata);
        end

        bank_never = 1'b1;
        do_txn(1'b1, 4'd6, 1'b0, 4'd0, gid, rid, lat, rdata);
        chk("tmo_grant", gid, 0);
        chk("tmo_resp_id", rid, 0);
        chk("tmo_latency", lat, TIMEOUT);
        chk("tmo_data", rdata, 0);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_orv", open_row_valid, 0);
        $display("timeout grant=%0d resp=%0d lat=%0d data=%08h", gid, rid, lat, rdata);
        bank_never = 1'b0;
        do_txn(1'b0, 4'd0, 1'b1, 4'd6, gid, rid, lat, rdata);
        chk("post_tmo_grant", gid, 1);
        chk("post_tmo_latency", lat, miss_lat);
        chk("post_tmo_data", rdata, bank_data(4'd6));
        chk("post_tmo_err_sticky", timeout_err, 1);
        chk("post_tmo_orv", open_row_valid, 1);
        $display("after timeout grant=%0d resp=%0d lat=%0d data=%08h", gid, rid, lat, rdata);

        // Abort a read mid-WAIT with reset while the bank answers late
        bank_never = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 4'd10;
        #1;
        chk("rstw_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; bov_inject = 1'b1; req1_valid = 1'b1; req1_row = 4'd2;
        @(posedge clk);
        #1;
        chk_all_zero("rstw");
        @(negedge clk);
        rst = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bov_inject = 1'b0;
            #1;
            chk($sformatf("rstw_idle%0d_resp0", k), resp0_valid, 0);
            chk($sformatf("rstw_idle%0d_resp1", k), resp1_valid, 0);
            chk($sformatf("rstw_idle%0d_orv", k), open_row_valid, 0);
        end
        $display("reset mid-wait done");
        bank_never = 1'b0;

        // Random phase against the transaction-level model
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        miss_lat = $urandom_range(1, 4); salt = $urandom;
        m_open = 4'd0; m_orv = 1'b0; m_streak = 0; m_rr = 0; m_free = 0;
        m_pend = 1'b0; m_rcyc = 0; m_rid = 0; m_rdata = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (acc0 || !req0_valid) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_row   = pick_row();
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (acc1 || !req1_valid) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_row   = pick_row();
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            #1;
            chk("rnd_resp0", resp0_valid, m_pend && m_rcyc == cyc && m_rid == 0);
            chk("rnd_resp1", resp1_valid, m_pend && m_rcyc == cyc && m_rid == 1);
            if (m_pend && m_rcyc == cyc) begin
                chk("rnd_data", (m_rid == 0) ? resp0_data : resp1_data, m_rdata);
                $display("rnd cyc=%0d resp id=%0d data=%08h", cyc, m_rid, m_rdata);
                m_pend = 1'b0;
            end
            ew = -1;
            if (cyc >= m_free && (req0_valid || req1_valid)) begin
                if (req0_valid && req1_valid) begin
                    h0 = m_orv && req0_row == m_open;
                    h1 = m_orv && req1_row == m_open;
                    if (h0 != h1 && m_streak < MAX_HITS) begin
                        ew = h1 ? 1 : 0;
                        m_streak++;
                    end else begin
                        ew = m_rr;
                        m_streak = 0;
                    end
                end else begin
                    ew = req1_valid ? 1 : 0;
                    m_streak = 0;
                end
                mrow    = (ew == 1) ? req1_row : req0_row;
                mhit    = m_orv && mrow == m_open;
                m_pend  = 1'b1;
                m_rcyc  = cyc + 2 + (mhit ? 0 : miss_lat);
                m_rid   = ew;
                m_rdata = bank_data(mrow);
                m_open  = mrow;
                m_orv   = 1'b1;
                m_rr    = 1 - ew;
                m_free  = m_rcyc;
            end
            chk("rnd_ready0", req0_ready, ew == 0);
            chk("rnd_ready1", req1_ready, ew == 1);
            acc0 = req0_ready;
            acc1 = req1_ready;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
